lfp_product_accumulator: RTL
============================

Name: lfp_product_accumulator

Overview:
- Downstream consumer of the E3M4 log-domain multiplier in the LSTM datapath.
- Takes a stream of E4M4 products, each with a separate sign bit from upstream, and converts each product to signed fixed point.
- Accumulates the terms of one dot-product vector with saturation and hands the sum to the activation stage over a valid/ready handshake.
- Two-stage pipeline: convert, then accumulate.

Parameters:
- OUT_BIAS, 8, exponent bias of the E4M4 product format.
- FRAC, 8, number of fractional bits of the fixed-point accumulator.
- ACC_W, 24, accumulator and result width, two's complement.
- CNT_W, 8, width of the per-vector term counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- prod_valid  in  1  product beat valid.
- prod_ready  out  1  block can accept a product beat.
- prod_y  in  8  E4M4 product: exponent [7:4], mantissa [3:0].
- prod_sign  in  1  product sign, 1 = negative.
- prod_last  in  1  marks the final term of the vector.
- acc_valid  out  1  result valid.
- acc_ready  in  1  downstream accepts the result.
- acc_sum  out  ACC_W  signed saturated dot-product sum.
- acc_ovf  out  1  sticky: saturation occurred within this vector.
- acc_count  out  CNT_W  number of terms accumulated in this vector; wraps modulo 2^CNT_W.

Behaviour:
- Reset: asynchronous. All of the following clear immediately on rst, regardless of any vector in flight, which is discarded:
  - acc_valid=0, acc_sum=0, acc_ovf=0, acc_count=0;
  - stage-1 register empty; last_pending=0.
  - prod_ready=1 from the first cycle after rst deasserts.
- Accept rule: a beat is accepted when prod_valid & prod_ready.
- prod_ready = !last_pending.
  - last_pending sets when a beat with prod_last=1 is accepted.
  - It clears on the output handshake (acc_valid & acc_ready).
  - prod_ready therefore rises the cycle after the handshake.
- Conversion (stage 1, registered):
  - S = {1, M}, value 16..31; E = prod_y[7:4].
  - sh = E + FRAC - OUT_BIAS - 4, evaluated as a signed value.
  - mag = S << sh when sh >= 0; mag = S >> (-sh) when sh < 0, truncating.
  - prod_y == 8'h00 is exact zero: mag = 0.
  - term = prod_sign ? -mag : mag, sign-extended to ACC_W.
  - A negative zero becomes 0.
- Accumulate (stage 2): the stage-1 register is valid for exactly one cycle per accepted beat. On that cycle:
  - acc_sum <= sat(acc_sum + term).
  - acc_count <= acc_count + 1.
- Saturation:
  - Compute the sum at ACC_W+1 bits.
  - Clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - On clamp, set acc_ovf, which stays set until the vector is handed off.
- Latency: a last beat accepted in cycle N gives acc_valid=1 in cycle N+2, with the final sum, count and ovf.
- Output hold: while acc_valid=1, acc_sum, acc_ovf and acc_count are stable regardless of acc_ready.
- Handshake: on the cycle acc_valid & acc_ready, the next cycle has:
  - acc_valid=0, acc_sum=0, acc_ovf=0, acc_count=0;
  - prod_ready=1.
- Back-to-back vectors: no overlap. The next vector's first beat is accepted no earlier than the cycle after the handshake.
- prod_ready is never combinationally dependent on prod_valid.
- acc_valid is never combinationally dependent on acc_ready.
- Range: at the default parameters the maximum term is 31 << 11 = 63488. Any FRAC/OUT_BIAS combination must keep the maximum term at or below ACC_W-1 bits; this is checked by a static assertion.

Test Plan:
- Reset: assert rst mid-vector after 2 beats -> acc_valid=0, acc_sum=0 immediately. After release, prod_ready=1; a new single-term vector 0x84 yields acc_sum=320.
- Single term: prod_y=0x84, sign=0, last=1 at cycle N -> acc_valid at N+2, acc_sum=320, acc_count=1, acc_ovf=0.
- Three terms, in order:
  - 0x84 positive;
  - 0x80 negative;
  - 0x90 positive, last;
  - -> acc_sum = 320 - 256 + 512 = 576, acc_count=3.
- Small and zero values: 0x0F positive (31>>4 = 1), 0x00 negative, 0x00 positive last -> acc_sum=1, no negative-zero artefact.
- Saturation: 140 beats of 0xFF positive, last on the 140th -> acc_sum=8388607, acc_ovf=1, acc_count=140.
- Backpressure: hold acc_ready=0 for 5 cycles with prod_valid=1 -> prod_ready=0 and outputs stable throughout. After the handshake the next vector starts from acc_sum=0 with acc_ovf cleared.

Source files
------------

// File: rtl/lfp_product_accumulator.sv
// Converts sign/E4M4 log-domain products to signed fixed point and accumulates one
// dot-product vector with saturation, handing the sum downstream over valid/ready.
module lfp_product_accumulator #(
    parameter int OUT_BIAS = 8,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [7:0]       prod_y,
    input  logic             prod_sign,
    input  logic             prod_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_sum,
    output logic             acc_ovf,
    output logic [CNT_W-1:0] acc_count
);

    localparam int SH_OFF = FRAC - OUT_BIAS - 4;
    localparam int MAX_SH = 15 + SH_OFF;

    // The largest significand (31) is 5 bits wide; shifted by MAX_SH it must still fit
    // below the accumulator's sign bit.
    generate
        if (MAX_SH + 5 > ACC_W - 1) begin : g_rangeCheck
            $error("lfp_product_accumulator: maximum term does not fit in ACC_W-1 bits");
        end
    endgenerate

    logic             r_lastPending;
    logic             r_s1Valid;
    logic             r_s1Last;
    logic [ACC_W-1:0] r_s1Term;
    logic             r_accValid;
    logic [ACC_W-1:0] r_accSum;
    logic             r_accOvf;
    logic [CNT_W-1:0] r_accCount;

    logic             w_accept;
    logic             w_handshake;
    int               w_shAmt;
    logic [4:0]       w_sig;
    logic [ACC_W-1:0] w_sigExt;
    logic [ACC_W-1:0] w_mag;
    logic [ACC_W-1:0] w_term;
    logic [ACC_W:0]   w_sumWide;
    logic             w_clamp;
    logic [ACC_W-1:0] w_sumSat;

    assign prod_ready  = !r_lastPending;
    assign w_accept    = prod_valid & prod_ready;
    assign w_handshake = r_accValid & acc_ready;

    assign acc_valid = r_accValid;
    assign acc_sum   = r_accSum;
    assign acc_ovf   = r_accOvf;
    assign acc_count = r_accCount;

    // Product conversion: {1,M} scaled by 2^(E + FRAC - OUT_BIAS - 4); 8'h00 is exact zero.
    always_comb begin
        w_shAmt  = int'({28'd0, prod_y[7:4]}) + SH_OFF;
        w_sig    = {1'b1, prod_y[3:0]};
        w_sigExt = {{(ACC_W-5){1'b0}}, w_sig};
        w_mag    = '0;
        if (prod_y == 8'h00) begin
            w_mag = '0;
        end else if (w_shAmt >= 0) begin
            w_mag = w_sigExt << w_shAmt;
        end else begin
            w_mag = w_sigExt >> (-w_shAmt);
        end
        w_term = prod_sign ? (-w_mag) : w_mag;
    end

    always_comb begin
        w_sumWide = {r_accSum[ACC_W-1], r_accSum} + {r_s1Term[ACC_W-1], r_s1Term};
        w_clamp   = w_sumWide[ACC_W] != w_sumWide[ACC_W-1];
        w_sumSat  = w_sumWide[ACC_W-1:0];
        if (w_clamp) begin
            w_sumSat = w_sumWide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Input gating: once the last beat of a vector is in, stall until the sum is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastPending <= 1'b0;
        end else if (w_handshake) begin
            r_lastPending <= 1'b0;
        end else if (w_accept && prod_last) begin
            r_lastPending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Last  <= 1'b0;
            r_s1Term  <= '0;
        end else begin
            r_s1Valid <= w_accept;
            r_s1Last  <= w_accept & prod_last;
            if (w_accept) begin
                r_s1Term <= w_term;
            end
        end
    end

    // Accumulator; no term can be in flight while a result is held, so the
    // handshake clear and an accumulate never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_accValid <= 1'b0;
            r_accSum   <= '0;
            r_accOvf   <= 1'b0;
            r_accCount <= '0;
        end else if (w_handshake) begin
            r_accValid <= 1'b0;
            r_accSum   <= '0;
            r_accOvf   <= 1'b0;
            r_accCount <= '0;
        end else if (r_s1Valid) begin
            r_accSum   <= w_sumSat;
            r_accCount <= r_accCount + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_clamp) begin
                r_accOvf <= 1'b1;
            end
            if (r_s1Last) begin
                r_accValid <= 1'b1;
            end
        end
    end

endmodule
